m3_dequant_writer: RTL and testbench
====================================

M3_DEQUANT_WRITER -- requirements
Module: m3_dequant_writer

Interface
REQ-001 Clock_50  in  1  sole clock; all state changes on its rising edge.
REQ-002 Reset  in  1  synchronous, active-high reset, sampled on the Clock_50 rising edge.
REQ-003 start  in  1  one-cycle pulse that begins one 8x8 block; ignored unless in S_IDLE.
REQ-004 q_matrix  in  1  quantization table select (0=Q0, 1=Q1), latched at start.
REQ-005 coeff_valid  in  1  upstream decoder offers a token.
REQ-006 coeff_ready  out  1  block accepts a token; a token transfers when valid and ready are both 1.
REQ-007 coeff_data  in  16  signed quantized coefficient.
REQ-008 coeff_run  in  6  count of zero coefficients preceding coeff_data in zigzag order.
REQ-009 coeff_eob  in  1  end of block: all remaining positions are zero; coeff_data and coeff_run are ignored.
REQ-010 DP_RAM_address  out  7  row-major write address, 0..63.
REQ-011 DP_RAM_write_data  out  32  dequantized value, sign-extended from 16 bits.
REQ-012 DP_RAM_we  out  1  write enable.
REQ-013 M3_finish  out  1  one-cycle pulse when all 64 positions have been written.
REQ-014 error  out  1  sticky flag for a run overflow; cleared at start.

Function
REQ-015 States SHALL be S_IDLE, S_ACCEPT, S_ZERO_RUN, S_WRITE_COEFF, S_ZERO_FILL and S_DONE; all outputs are registered.
REQ-016 S_IDLE: on start, SHALL clear the zigzag index k to 0 and clear error, latch q_matrix, and go to S_ACCEPT.
REQ-017 S_ACCEPT: coeff_ready=1. On a transfer with eob=1, go to S_ZERO_FILL. On a transfer with run>0, latch the token and go to S_ZERO_RUN. Otherwise go to S_WRITE_COEFF.
REQ-018 coeff_ready SHALL be 0 in every state other than S_ACCEPT.
REQ-019 S_ZERO_RUN: SHALL write 0 at address zz(k) with we=1, increment k and decrement the remaining run, one write per cycle; when the run is exhausted, go to S_WRITE_COEFF.
REQ-020 S_WRITE_COEFF: SHALL write deq(coeff, k) at zz(k) with we=1 and increment k; if k was 63, go to S_DONE, else go to S_ACCEPT.
REQ-021 S_ZERO_FILL: SHALL write 0 at zz(k) once per cycle until k=63 has been written, then go to S_DONE.
REQ-022 zz(k) SHALL be the standard JPEG zigzag-to-row-major mapping; for example zz(0)=0, zz(1)=1, zz(2)=8, zz(3)=16, zz(63)=63.
REQ-023 deq(c,k) = c << sh, where s = row+col of zz(k) and sh is looked up from the latched table.
REQ-024 Q0 shift by s: s=0 -> 3, s=1 -> 2, s=2 -> 3, s=3 -> 4, s=4..5 -> 5, s>=6 -> 6.
REQ-025 Q1 shift by s: s=0 -> 3, s=1..3 -> 1, s=4 -> 2, s=5 -> 3, s=6 -> 4, s>=7 -> 5.
REQ-026 The shifted result SHALL saturate to the range [-32768, 32767] before sign extension to 32 bits.
REQ-027 Run overflow: if k+run > 63, the block SHALL write zeros through k=63, discard the coefficient, set error, then go to S_DONE.
REQ-028 A coefficient at k=63 SHALL end the block without an EOB token.
REQ-029 An EOB received when k=0 SHALL produce 64 zero writes.
REQ-030 S_DONE: we=0; M3_finish=1 for exactly one cycle; then go to S_IDLE.
REQ-031 Exactly 64 writes SHALL occur per block, with each address 0..63 written exactly once.
REQ-032 Throughput: one RAM write per cycle during runs and fill; a token with run r costs r+2 cycles.

Reset
REQ-033 While Reset=1: state=S_IDLE, k=0, DP_RAM_address=0, DP_RAM_write_data=0, DP_RAM_we=0, coeff_ready=0, M3_finish=0, error=0.
REQ-034 Reset asserted mid-block SHALL abandon the block with no further writes and no M3_finish pulse.

Structure
REQ-035 A shared package m3_pkg SHALL hold the state enum, the 64-entry zigzag LUT and the Q0/Q1 shift tables.
REQ-036 Sub-module m3_dequant SHALL hold the combinational shift, saturation and sign extension.

Verification
REQ-037 q_matrix=0; tokens (data=5,run=0), (data=-2,run=0), then EOB -> writes 40@0 and -8@1, zeros at the other 62 addresses, one M3_finish pulse.
REQ-038 q_matrix=1; token (data=3,run=2) -> writes 0@0, 0@1, 6@8 (k=2, s=1, shift 1); coeff_ready low for 3 cycles.
REQ-039 q_matrix=0; token (data=32767,run=63) -> 63 zeros, then 32767@63 saturated, M3_finish without EOB.
REQ-040 Tokens (run=60), then (data=1,run=5) -> zeros through k=63, coefficient dropped, error=1, exactly 64 writes.
REQ-041 coeff_valid toggled randomly; Reset pulsed after 10 writes -> we=0 next cycle, no M3_finish; a following start completes normally.

Source files
------------

// File: rtl/m3_pkg.sv
// m3_pkg: state encoding, zigzag order and per-table shift amounts for the dequantizing block writer
package m3_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_ZERO_RUN,
    S_WRITE_COEFF,
    S_ZERO_FILL,
    S_DONE
  } state_t;
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };
  // indexed by row+col (0..14); entry 15 is never reached
  localparam logic [2:0] Q0_SH [16] = '{
    3'd3, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd6,
    3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6
  };
  localparam logic [2:0] Q1_SH [16] = '{
    3'd3, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
    3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5
  };
endpackage

// File: rtl/m3_dequant.sv
// m3_dequant: shift a quantized coefficient by its table entry, saturate to 16 bits, sign-extend
module m3_dequant
  import m3_pkg::*;
(
  input  logic [15:0] coeff,
  input  logic [5:0]  k,
  input  logic        sel,
  output logic [31:0] value
);
  logic [5:0]  pos;
  logic [3:0]  s;
  logic [2:0]  sh;
  logic [21:0] v;
  logic [15:0] sat;
  assign pos = ZZ[k];
  assign s = {1'b0, pos[5:3]} + {1'b0, pos[2:0]};
  assign sh = sel ? Q1_SH[s] : Q0_SH[s];
  assign v = {{6{coeff[15]}}, coeff} << sh;
  // in range only when bits 21..15 are all copies of the sign
  assign sat = (v[21:15] == '0 || v[21:15] == '1) ? v[15:0] : v[21] ? 16'h8000 : 16'h7fff;
  assign value = {{16{sat[15]}}, sat};
endmodule

// File: rtl/m3_dequant_writer.sv
// m3_dequant_writer: expands run-length coefficient tokens into 64 dequantized row-major RAM writes
module m3_dequant_writer
  import m3_pkg::*;
(
  input  logic        Clock_50,
  input  logic        Reset,
  input  logic        start,
  input  logic        q_matrix,
  input  logic        coeff_valid,
  output logic        coeff_ready,
  input  logic [15:0] coeff_data,
  input  logic [5:0]  coeff_run,
  input  logic        coeff_eob,
  output logic [6:0]  DP_RAM_address,
  output logic [31:0] DP_RAM_write_data,
  output logic        DP_RAM_we,
  output logic        M3_finish,
  output logic        error
);
  state_t      state, next;
  logic [5:0]  k, run;
  logic [15:0] coeff;
  logic        qsel, take, last, writing;
  logic [31:0] deq;
  m3_dequant dq (
    .coeff(coeff),
    .k(k),
    .sel(qsel),
    .value(deq)
  );
  assign take = coeff_valid && coeff_ready;
  assign last = k == 6'd63;
  assign writing = state inside {S_ZERO_RUN, S_WRITE_COEFF, S_ZERO_FILL};
  always_ff @(posedge Clock_50) begin
    if (Reset) state <= S_IDLE;
    else state <= next;
  end
  always_comb begin
    next = state;
    case (state)
      S_IDLE: next = start ? S_ACCEPT : S_IDLE;
      S_ACCEPT: if (take) next = coeff_eob ? S_ZERO_FILL : coeff_run != 6'd0 ? S_ZERO_RUN : S_WRITE_COEFF;
      S_ZERO_RUN: next = last ? S_DONE : run == 6'd1 ? S_WRITE_COEFF : S_ZERO_RUN;
      S_WRITE_COEFF: next = last ? S_DONE : S_ACCEPT;
      S_ZERO_FILL: next = last ? S_DONE : S_ZERO_FILL;
      default: next = S_IDLE;
    endcase
  end
  // outputs present the write issued by the previous cycle's state
  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      k <= '0;
      run <= '0;
      coeff <= '0;
      qsel <= 1'b0;
      error <= 1'b0;
      coeff_ready <= 1'b0;
      DP_RAM_address <= '0;
      DP_RAM_write_data <= '0;
      DP_RAM_we <= 1'b0;
      M3_finish <= 1'b0;
    end else begin
      coeff_ready <= next == S_ACCEPT;
      DP_RAM_we <= writing;
      DP_RAM_address <= {1'b0, ZZ[k]};
      DP_RAM_write_data <= state == S_WRITE_COEFF ? deq : '0;
      M3_finish <= state == S_DONE;
      if (state == S_IDLE && start) begin
        k <= '0;
        error <= 1'b0;
        qsel <= q_matrix;
      end
      if (take) begin
        run <= coeff_run;
        coeff <= coeff_data;
      end
      if (writing) k <= k + 6'd1;
      if (state == S_ZERO_RUN) begin
        run <= run - 6'd1;
        if (last) error <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_m3_dequant_writer.sv
// tb_m3_dequant_writer: table-driven blocks plus corner sequences, writes checked against a scoreboard
module tb_m3_dequant_writer;
  logic        Clock_50 = 1'b0, Reset = 1'b1, start = 1'b0, q_matrix = 1'b0;
  logic        coeff_valid = 1'b0, coeff_eob = 1'b0;
  logic [15:0] coeff_data = '0;
  logic [5:0]  coeff_run = '0;
  logic        coeff_ready, DP_RAM_we, M3_finish, error;
  logic [6:0]  DP_RAM_address;
  logic [31:0] DP_RAM_write_data;
  typedef struct {int addr; int data;} wr_t;
  typedef struct {bit q; int d; int run; int expv;} vec_t;
  wr_t  exp_q[$];
  wr_t  mon_e;
  vec_t vecs[10];
  int   zz[64];
  int   checks = 0, failures = 0, wr_cnt = 0, fin_cnt = 0, wr_base = 0;

  always #5 Clock_50 = ~Clock_50;

  m3_dequant_writer dut (
    .Clock_50(Clock_50), .Reset(Reset), .start(start), .q_matrix(q_matrix),
    .coeff_valid(coeff_valid), .coeff_ready(coeff_ready), .coeff_data(coeff_data),
    .coeff_run(coeff_run), .coeff_eob(coeff_eob), .DP_RAM_address(DP_RAM_address),
    .DP_RAM_write_data(DP_RAM_write_data), .DP_RAM_we(DP_RAM_we),
    .M3_finish(M3_finish), .error(error)
  );

  always @(negedge Clock_50) begin
    if (M3_finish) fin_cnt++;
    if (DP_RAM_we) begin
      wr_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%0d data=%0d required=no write", DP_RAM_address, $signed(DP_RAM_write_data));
      end else begin
        mon_e = exp_q.pop_front();
        if (int'(DP_RAM_address) != mon_e.addr || $signed(DP_RAM_write_data) != mon_e.data) begin
          failures++;
          $display("FAIL write actual=%0d@%0d required=%0d@%0d", $signed(DP_RAM_write_data), DP_RAM_address, mon_e.data, mon_e.addr);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic expect_block(input int ka, input int va, input int kb, input int vb);
    for (int k = 0; k < 64; k++) begin
      wr_t e;
      e.addr = zz[k];
      e.data = k == ka ? va : k == kb ? vb : 0;
      exp_q.push_back(e);
    end
  endtask

  task automatic start_block(input bit q);
    wr_base = wr_cnt;
    start = 1'b1;
    q_matrix = q;
    @(posedge Clock_50); #1;
    start = 1'b0;
  endtask

  task automatic send(input int d, input int r, input bit e, input bit rnd);
    int n;
    bit done;
    n = 0;
    done = 0;
    coeff_data = 16'(d);
    coeff_run = 6'(r);
    coeff_eob = e;
    while (!done && n < 300) begin
      coeff_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge Clock_50);
      done = coeff_valid && coeff_ready;
      @(posedge Clock_50); #1;
      n++;
    end
    coeff_valid = 1'b0;
    check("handshake", int'(done), 1);
  endtask

  task automatic count_ready_low(input int req);
    int n;
    n = 0;
    @(negedge Clock_50);
    while (!coeff_ready && n < 100) begin
      n++;
      @(negedge Clock_50);
    end
    check("ready_low_cycles", n, req);
    @(posedge Clock_50); #1;
  endtask

  task automatic wait_finish(input int exp_err);
    int base, n;
    base = fin_cnt;
    n = 0;
    while (fin_cnt == base && n < 400) begin
      @(negedge Clock_50); #1;
      n++;
    end
    check("finish_seen", fin_cnt - base, 1);
    check("write_count", wr_cnt - wr_base, 64);
    check("queue_left", exp_q.size(), 0);
    check("error_flag", int'(error), exp_err);
    @(negedge Clock_50); #1;
    check("finish_width", int'(M3_finish), 0);
    @(posedge Clock_50); #1;
  endtask

  initial begin
    int n, r, c, base;
    n = 0;
    for (int s = 0; s < 15; s++)
      for (int i = 0; i < 8; i++) begin
        r = (s % 2 == 1) ? i : 7 - i;
        c = s - r;
        if (c >= 0 && c < 8) begin
          zz[n] = r * 8 + c;
          n++;
        end
      end
    vecs = '{'{0, 5, 0, 40}, '{0, -2, 1, -8}, '{1, 3, 2, 6}, '{0, 7, 4, 56},
             '{1, -100, 10, -400}, '{0, 1000, 20, 32000}, '{0, 1024, 21, 32767},
             '{1, -5, 35, -160}, '{0, 32767, 63, 32767}, '{1, -32768, 63, -32768}};
    repeat (3) @(posedge Clock_50);
    @(negedge Clock_50);
    check("rst_addr", int'(DP_RAM_address), 0);
    check("rst_data", int'(DP_RAM_write_data), 0);
    check("rst_we", int'(DP_RAM_we), 0);
    check("rst_ready", int'(coeff_ready), 0);
    check("rst_finish", int'(M3_finish), 0);
    check("rst_error", int'(error), 0);
    @(posedge Clock_50); #1;
    Reset = 1'b0;
    foreach (vecs[i]) begin
      expect_block(vecs[i].run, vecs[i].expv, -1, 0);
      start_block(vecs[i].q);
      send(vecs[i].d, vecs[i].run, 0, 0);
      if (vecs[i].run < 63) begin
        count_ready_low(vecs[i].run + 1);
        send(0, 0, 1, 0);
      end
      wait_finish(0);
    end
    expect_block(0, 40, 1, -8);
    start_block(0);
    send(5, 0, 0, 0);
    send(-2, 0, 0, 0);
    send(0, 0, 1, 0);
    wait_finish(0);
    expect_block(-1, 0, -1, 0);
    start_block(1);
    send(0, 0, 1, 0);
    wait_finish(0);
    expect_block(-1, 0, -1, 0);
    start_block(0);
    send(0, 60, 0, 0);
    send(1, 5, 0, 0);
    wait_finish(1);
    expect_block(-1, 0, -1, 0);
    start_block(0);
    @(negedge Clock_50); #1;
    check("error_cleared", int'(error), 0);
    @(posedge Clock_50); #1;
    send(0, 0, 1, 0);
    wait_finish(0);
    expect_block(0, 40, 1, -8);
    start_block(0);
    send(5, 0, 0, 1);
    send(-2, 0, 0, 1);
    send(0, 0, 1, 1);
    n = 0;
    while (wr_cnt - wr_base < 10 && n < 200) begin
      @(negedge Clock_50); #1;
      n++;
    end
    check("writes_before_reset", wr_cnt - wr_base, 10);
    base = fin_cnt;
    Reset = 1'b1;
    exp_q.delete();
    repeat (3) begin
      @(negedge Clock_50);
      check("reset_we", int'(DP_RAM_we), 0);
    end
    check("reset_no_finish", fin_cnt - base, 0);
    check("reset_no_more_writes", wr_cnt - wr_base, 10);
    @(posedge Clock_50); #1;
    Reset = 1'b0;
    expect_block(0, 40, 1, -8);
    start_block(0);
    send(5, 0, 0, 1);
    send(-2, 0, 0, 1);
    send(0, 0, 1, 1);
    wait_finish(0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
